// File: rtl/sipo_capture.sv
// Serial-in, parallel-out capture: assembles WIDTH serial bits into a word and
// presents it on a one-deep valid/ready output register with a sticky overrun flag.
module sipo_capture #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclr,
    input  logic             din,
    input  logic             din_en,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             overrun
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic [CW-1:0]    cnt;
    logic             complete;
    logic             pop;
    logic             load;

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign sr_next = {sr[WIDTH-2:0], din};
        end else begin : g_lsb_first
            assign sr_next = {din, sr[WIDTH-1:1]};
        end
    endgenerate

    // Handshake: a word transfers on any edge where dout_valid=1 and dout_ready=1;
    // dout_valid never depends on dout_ready, and dout is stable while valid and not ready.
    assign complete = din_en && (cnt == CNT_LAST);
    assign pop      = dout_valid && dout_ready;
    assign load     = complete && (!dout_valid || dout_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr         <= '0;
            cnt        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else if (sclr) begin
            sr         <= '0;
            cnt        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (din_en) begin
                sr  <= sr_next;
                cnt <= complete ? '0 : cnt + CW'(1);
            end
            // A completed word loads in the same edge it finishes; a full, stalled
            // output register drops it and raises the sticky overrun flag.
            if (load) begin
                dout       <= sr_next;
                dout_valid <= 1'b1;
            end else if (complete) begin
                overrun <= 1'b1;
            end else if (pop) begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_capture.sv
// Directed bench for sipo_capture: two instances (MSB-first and LSB-first) share
// stimulus; expected values are hand-computed constants.
module tb_sipo_capture;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             sclr = 1'b0;
    logic             din = 1'b0;
    logic             din_en = 1'b0;
    logic             dout_ready = 1'b0;
    logic [WIDTH-1:0] dout_m;
    logic             valid_m;
    logic             overrun_m;
    logic [WIDTH-1:0] dout_l;
    logic             valid_l;
    logic             overrun_l;

    int checks = 0;
    int failures = 0;

    sipo_capture #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .sclr(sclr), .din(din), .din_en(din_en),
        .dout(dout_m), .dout_valid(valid_m), .dout_ready(dout_ready),
        .overrun(overrun_m)
    );

    sipo_capture #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .sclr(sclr), .din(din), .din_en(din_en),
        .dout(dout_l), .dout_valid(valid_l), .dout_ready(dout_ready),
        .overrun(overrun_l)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        din    = b;
        din_en = 1'b1;
        tick();
        din_en = 1'b0;
    endtask

    // Sends bits w[hi] down to w[lo] on consecutive edges.
    task automatic send_bits(input logic [WIDTH-1:0] w, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) send_bit(w[i]);
    endtask

    task automatic do_sclr();
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        check("reset_dout", dout_m, 8'h00);
        check("reset_valid", valid_m, 1'b0);
        check("reset_overrun", overrun_m, 1'b0);
        tick();
        #2 rst = 1'b1;
        tick();

        // 0xA5 MSB first, no ready; word not visible one bit early
        send_bits(8'hA5, 7, 1);
        check("a5_valid_after7", valid_m, 1'b0);
        send_bits(8'hA5, 0, 0);
        check("a5_dout", dout_m, 8'hA5);
        check("a5_valid", valid_m, 1'b1);
        check("a5_overrun", overrun_m, 1'b0);

        // Backpressure: 0x3C dropped
        send_bits(8'h3C, 7, 0);
        check("bp_dout", dout_m, 8'hA5);
        check("bp_valid", valid_m, 1'b1);
        check("bp_overrun", overrun_m, 1'b1);
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        check("pop_valid", valid_m, 1'b0);
        check("pop_dout_hold", dout_m, 8'hA5);
        check("pop_overrun_sticky", overrun_m, 1'b1);

        // Simultaneous pop and complete
        do_sclr();
        send_bits(8'hA5, 7, 0);
        send_bits(8'h3C, 7, 1);
        check("sim_hold_dout", dout_m, 8'hA5);
        dout_ready = 1'b1;
        send_bits(8'h3C, 0, 0);
        dout_ready = 1'b0;
        check("sim_dout", dout_m, 8'h3C);
        check("sim_valid", valid_m, 1'b1);
        check("sim_overrun", overrun_m, 1'b0);

        // Bit order
        do_sclr();
        send_bits(8'h80, 7, 0);
        check("order_msb_dout", dout_m, 8'h80);
        check("order_lsb_dout", dout_l, 8'h01);
        check("order_lsb_valid", valid_l, 1'b1);

        // Async reset mid-word, including an edge while held low
        send_bits(8'hE0, 7, 5);
        #2 rst = 1'b0;
        #1;
        check("arst_dout", dout_m, 8'h00);
        check("arst_valid", valid_m, 1'b0);
        check("arst_overrun", overrun_m, 1'b1 & 1'b0);
        din_en = 1'b1;
        din = 1'b1;
        sclr = 1'b0;
        tick();
        din_en = 1'b0;
        check("arst_hold_valid", valid_m, 1'b0);
        #2 rst = 1'b1;
        tick();
        send_bits(8'hFF, 7, 1);
        check("ff_valid_after7", valid_m, 1'b0);
        send_bits(8'hFF, 0, 0);
        check("ff_dout", dout_m, 8'hFF);
        check("ff_valid", valid_m, 1'b1);

        // Gaps of two idle cycles between bits
        do_sclr();
        for (int i = 7; i >= 0; i--) begin
            send_bit(8'h5A >> i);
            if (i > 0) begin
                tick();
                tick();
            end
        end
        check("gap_dout", dout_m, 8'h5A);
        check("gap_valid", valid_m, 1'b1);

        // sclr on a complete edge that would otherwise overrun
        send_bits(8'h81, 7, 1);
        sclr   = 1'b1;
        din    = 1'b1;
        din_en = 1'b1;
        tick();
        sclr   = 1'b0;
        din_en = 1'b0;
        check("sclr_valid", valid_m, 1'b0);
        check("sclr_dout", dout_m, 8'h00);
        check("sclr_overrun", overrun_m, 1'b0);
        send_bits(8'hC3, 7, 0);
        check("post_sclr_dout", dout_m, 8'hC3);
        check("post_sclr_valid", valid_m, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sipo_capture.md
SIPO_CAPTURE -- requirements
Module: sipo_capture

Interface
- REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of bits per captured word (legal range 2..32).
- REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 means the first serial bit lands in dout[WIDTH-1]; 0 means it lands in dout[0].
- REQ-003 Port clk, input, width 1: the single clock; all state updates on its rising edge.
- REQ-004 Port rst, input, width 1: asynchronous, active-low reset.
- REQ-005 Port sclr, input, width 1: synchronous clear.
- REQ-006 Port din, input, width 1: serial data bit, typically a registered DFF q.
- REQ-007 Port din_en, input, width 1: din is sampled on each rising edge where din_en=1.
- REQ-008 Port dout, output, width WIDTH: the captured parallel word.
- REQ-009 Port dout_valid, output, width 1: dout holds an unconsumed word.
- REQ-010 Port dout_ready, input, width 1: the consumer accepts dout on an edge where dout_valid=1 and dout_ready=1.
- REQ-011 Port overrun, output, width 1: sticky flag set when a completed word is dropped.

Function
- REQ-012 Internal state SHALL be: shift register sr[WIDTH-1:0]; bit counter cnt (range 0..WIDTH-1); output register dout; dout_valid; overrun.
- REQ-013 On an edge with din_en=1, sr SHALL shift:
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], din}.
  - MSB_FIRST=0: sr <= {din, sr[WIDTH-1:1]}.
- REQ-014 On an edge with din_en=1, cnt SHALL increment; it SHALL wrap from WIDTH-1 to 0.
- REQ-015 On an edge with din_en=0, sr and cnt SHALL hold.
- REQ-016 "complete" SHALL be true on an edge where din_en=1 and cnt=WIDTH-1; the completed word is the post-shift value of sr.
- REQ-017 Latency: after the edge that samples the last bit, dout and dout_valid=1 SHALL be visible, with no additional cycle of delay.
- REQ-018 Load: on complete with (dout_valid=0 or dout_ready=1), dout SHALL take the completed word and dout_valid SHALL be 1.
- REQ-019 Pop: on an edge with dout_valid=1, dout_ready=1 and no complete, dout_valid SHALL go to 0 and dout SHALL hold its value.
- REQ-020 Simultaneous pop and complete: the new word SHALL load and dout_valid SHALL stay 1, with no bubble cycle.
- REQ-021 Drop: on complete with dout_valid=1 and dout_ready=0:
  - the new word SHALL be discarded;
  - dout SHALL be unchanged;
  - overrun SHALL be set to 1;
  - cnt SHALL still wrap to 0.
- REQ-022 overrun SHALL remain 1 until sclr or reset clears it.
- REQ-023 While dout_valid=1 and dout_ready=0, dout SHALL be stable.
- REQ-024 dout_ready SHALL be ignored while dout_valid=0.
- REQ-025 sclr=1 SHALL take priority over din_en and dout_ready, and SHALL clear sr, cnt, dout, dout_valid and overrun to 0 on that edge.
- REQ-026 A din_en gap of any length between bits SHALL NOT disturb the partially assembled word.

Reset
- REQ-027 When rst=0, the block SHALL immediately, without waiting for a clock edge, force sr=0, cnt=0, dout=0, dout_valid=0 and overrun=0.
- REQ-028 Outputs SHALL hold their reset values while rst=0 regardless of clk, din_en, sclr or dout_ready.
- REQ-029 Reset asserted mid-word SHALL discard the partial word; the first din_en after rst returns to 1 is bit 0 of a new word.
- REQ-030 Deassertion of rst SHALL take effect at the first rising clk edge after rst=1.

Verification (WIDTH=8 unless noted)
- REQ-031 MSB_FIRST=1, dout_ready=0, din_en=1 on every edge, din sequence 1,0,1,0,0,1,0,1 -> after the 8th edge: dout=0xA5, dout_valid=1, overrun=0.
- REQ-032 Backpressure: starting from REQ-031's end state, with dout_ready=0, shift 0x3C -> dout stays 0xA5 and overrun=1. Then dout_ready=1 for one edge -> dout_valid=0, and overrun stays 1.
- REQ-033 Simultaneous pop and complete: dout=0xA5 valid, and dout_ready=1 on the edge that completes 0x3C -> dout=0x3C, dout_valid=1, overrun=0.
- REQ-034 Bit order: send din sequence 1,0,0,0,0,0,0,0 -> dout=0x80 with MSB_FIRST=1; dout=0x01 with MSB_FIRST=0.
- REQ-035 Async reset mid-word: after 3 bits, pulse rst low between clock edges -> all outputs are 0 immediately. Then sending 0xFF -> dout=0xFF after exactly 8 din_en edges.
- REQ-036 Gaps and sclr:
  - 0x5A sent with din_en=0 for 2 cycles between every bit -> dout=0x5A.
  - sclr=1 asserted on a complete edge -> dout_valid=0, dout=0, overrun=0.
